// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: opcode encoding
// and the pipeline-depth helper used by addsub_pipe.
package addsub_pkg;

    // Operation select carried on the `sub` input.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // One register stage resolves one CHUNK-bit slice of the carry chain.
    function automatic int calc_stages(input int n, input int chunk);
        return n / chunk;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One CHUNK-bit slice of the split carry chain: combinational add with
// carry in/out, plus the signed-overflow term that is only meaningful when
// this slice holds the operand MSBs.
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Slice sum with carry, and overflow when operand signs agree but the result sign differs.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        ovf         = (a[CHUNK-1] == b[CHUNK-1]) && (sum[CHUNK-1] != a[CHUNK-1]);
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined N-bit adder/subtractor with valid/ready on both sides. The carry
// chain is cut into CHUNK-bit slices, one per register stage, so latency is
// N/CHUNK cycles and throughput is one operation per clock.
// Optional feature macro: ADDSUB_SAT_EN adds a `sat` input that clamps the
// result to the signed range on overflow (clamp applied in the final stage).
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
`ifdef ADDSUB_SAT_EN
    input  logic         sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         carry_out,
    output logic         overflow,
    output logic         zero,
    output logic         negative
);

    localparam int STAGES = calc_stages(N, CHUNK);
    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    // Values entering each stage (stage 0 from the ports, later ones from registers).
    logic [N-1:0]     st_a   [STAGES];
    logic [N-1:0]     st_b   [STAGES];
    logic [N-1:0]     st_res [STAGES];
    logic             st_c   [STAGES];
    logic             st_sat [STAGES];
    logic [N-1:0]     nxt_res[STAGES];

    // Slice outputs.
    logic [CHUNK-1:0] sum_s  [STAGES];
    logic             cout_s [STAGES];
    logic             ovf_s  [STAGES];

    // Stage registers: skewed operands, partial results, carries, valid chain.
    logic [N-1:0]     a_p    [STAGES];
    logic [N-1:0]     b_p    [STAGES];
    logic [N-1:0]     res_p  [STAGES];
    logic             c_p    [STAGES];
    logic             sat_p  [STAGES];
    logic             vld_p  [STAGES];

    // Output registers.
    logic [N-1:0]     y_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;

    logic [N-1:0]     y_fin;
    logic             sat_in;
    logic             advance;

`ifdef ADDSUB_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    // The whole pipe moves together unless a finished result is waiting on the consumer.
    assign advance   = !vld_p[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_p[STAGES-1];
    assign y         = y_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

    // Route stage inputs: b is inverted for subtraction and the +1 enters as stage-0 carry.
    always_comb begin
        st_a[0]   = a;
        st_b[0]   = b ^ {N{sub}};
        st_c[0]   = (op_e'(sub) == OP_SUB);
        st_res[0] = '0;
        st_sat[0] = sat_in;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k]   = a_p[k-1];
            st_b[k]   = b_p[k-1];
            st_c[k]   = c_p[k-1];
            st_res[k] = res_p[k-1];
            st_sat[k] = sat_p[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        addsub_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (st_a[k][k*CHUNK +: CHUNK]),
            .b    (st_b[k][k*CHUNK +: CHUNK]),
            .cin  (st_c[k]),
            .sum  (sum_s[k]),
            .cout (cout_s[k]),
            .ovf  (ovf_s[k])
        );
    end

    // Merge each stage's freshly computed slice into the de-skewed partial result.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_res[k] = st_res[k];
            nxt_res[k][k*CHUNK +: CHUNK] = sum_s[k];
        end
    end

    // Final-stage clamp: positive overflow only happens when A is non-negative.
    always_comb begin
        y_fin = nxt_res[STAGES-1];
        if (st_sat[STAGES-1] && ovf_s[STAGES-1]) begin
            y_fin = st_a[STAGES-1][N-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // Pipeline and output registers; everything holds while a result is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                res_p[k] <= '0;
                c_p[k]   <= 1'b0;
                sat_p[k] <= 1'b0;
            end
            y_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else if (advance) begin
            // stage boundary: operand beat enters stage 0, every stage shifts one step
            vld_p[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                a_p[k]   <= st_a[k];
                b_p[k]   <= st_b[k];
                res_p[k] <= nxt_res[k];
                c_p[k]   <= cout_s[k];
                sat_p[k] <= st_sat[k];
            end
            // stage boundary: final slice result and flags
            y_q     <= y_fin;
            carry_q <= cout_s[STAGES-1];
            ovf_q   <= ovf_s[STAGES-1];
            zero_q  <= (y_fin == '0);
            neg_q   <= y_fin[N-1];
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: an 8-bit/4-bit-chunk instance for the
// main scenarios and a 32-bit/8-bit-chunk instance for the latency-4 case.
module tb_addsub_pipe;

`ifdef ADDSUB_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid8, in_ready8, sub8, sat8, out_valid8, out_ready8;
    logic        carry8, ovf8, zero8, neg8;
    logic [7:0]  a8, b8, y8;
    logic        in_valid32, in_ready32, sub32, sat32, out_valid32, out_ready32;
    logic        carry32, ovf32, zero32, neg32;
    logic [31:0] a32, b32, y32;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    int          obs_t[$];

    addsub_pipe #(.N(8), .CHUNK(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8),
`ifdef ADDSUB_SAT_EN
        .sat(sat8),
`endif
        .out_valid(out_valid8), .out_ready(out_ready8), .y(y8),
        .carry_out(carry8), .overflow(ovf8), .zero(zero8), .negative(neg8)
    );

    addsub_pipe #(.N(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .sub(sub32),
`ifdef ADDSUB_SAT_EN
        .sat(sat32),
`endif
        .out_valid(out_valid32), .out_ready(out_ready32), .y(y32),
        .carry_out(carry32), .overflow(ovf32), .zero(zero32), .negative(neg32)
    );

    // Reference: signed/unsigned integer arithmetic; returns {y, carry, overflow, zero, negative}.
    function automatic logic [11:0] model8(input logic [7:0] a, input logic [7:0] b,
                                           input logic s, input logic st);
        int ua, ub, sa, sb, sr;
        logic [7:0] yy;
        logic c, ov;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        if (!s) begin
            c = (ua + ub) > 255; yy = 8'(ua + ub); sr = sa + sb;
        end else begin
            c = (ua >= ub); yy = 8'(ua - ub); sr = sa - sb;
        end
        ov = (sr > 127) || (sr < -128);
        if (st && ov) yy = (sr > 127) ? 8'h7F : 8'h80;
        return {yy, c, ov, (yy == 8'h00), yy[7]};
    endfunction

    function automatic logic [35:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint ua, ub, sa, sb, sr;
        logic [31:0] yy;
        logic c, ov;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        if (!s) begin
            c = (ua + ub) > 64'sd4294967295; yy = 32'(ua + ub); sr = sa + sb;
        end else begin
            c = (ua >= ub); yy = 32'(ua - ub); sr = sa - sb;
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {yy, c, ov, (yy == 32'h0), yy[31]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard collection on the falling edge, where handshakes are stable.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid8 && in_ready8)
                exp_q.push_back(model8(a8, b8, sub8, sat8 & SAT_BUILD));
            if (out_valid8 && out_ready8) begin
                obs_q.push_back({y8, carry8, ovf8, zero8, neg8});
                obs_t.push_back(cyc);
            end
        end
    end

    task automatic clear_sb();
        exp_q.delete(); obs_q.delete(); obs_t.delete();
    endtask

    task automatic drive_one8(input logic [7:0] a, input logic [7:0] b, input logic s,
                              input logic st, output int lat, output logic [11:0] res);
        @(posedge clk); #1;
        a8 = a; b8 = b; sub8 = s; sat8 = st; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {y8, carry8, ovf8, zero8, neg8};
    endtask

    task automatic drive_one32(input logic [31:0] a, input logic [31:0] b, input logic s,
                               output int lat, output logic [35:0] res);
        @(posedge clk); #1;
        a32 = a; b32 = b; sub32 = s; in_valid32 = 1'b1; out_ready32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        lat = 1;
        while (!out_valid32 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {y32, carry32, ovf32, zero32, neg32};
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid8); end
        checks++; if (y8 !== 8'h00) begin errors++; $display("FAIL rst_y got=%h want=00", y8); end
        checks++; if ({carry8, ovf8, zero8, neg8} !== 4'b0000) begin errors++; $display("FAIL rst_flags got=%b want=0000", {carry8, ovf8, zero8, neg8}); end
        checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL rst_out_valid32 got=%b want=0", out_valid32); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", in_ready8); end
    endtask

    task automatic test_add();
        int lat; logic [11:0] r;
        drive_one8(8'd10, 8'd20, 1'b0, 1'b0, lat, r);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got=%0d want=2", lat); end
        checks++; if (r[11:4] !== 8'd30) begin errors++; $display("FAIL add_y got=%0d want=30", r[11:4]); end
        checks++; if (r[3:0] !== 4'b0000) begin errors++; $display("FAIL add_flags got=%b want=0000", r[3:0]); end
    endtask

    task automatic test_sub();
        int lat; logic [11:0] r;
        drive_one8(8'd20, 8'd10, 1'b1, 1'b0, lat, r);
        checks++; if (r[11:4] !== 8'd10) begin errors++; $display("FAIL sub_y got=%0d want=10", r[11:4]); end
        checks++; if (r[3:0] !== 4'b1000) begin errors++; $display("FAIL sub_flags got=%b want=1000", r[3:0]); end
        drive_one8(8'd10, 8'd10, 1'b1, 1'b0, lat, r);
        checks++; if (r[11:4] !== 8'd0) begin errors++; $display("FAIL sub_zero_y got=%0d want=0", r[11:4]); end
        checks++; if (r[3:0] !== 4'b1010) begin errors++; $display("FAIL sub_zero_flags got=%b want=1010", r[3:0]); end
    endtask

    task automatic test_overflow();
        int lat; logic [11:0] r;
        drive_one8(8'd127, 8'd1, 1'b0, 1'b0, lat, r);
        checks++; if (r[11:4] !== 8'd128) begin errors++; $display("FAIL ovf_add_y got=%0d want=128", r[11:4]); end
        checks++; if (r[3:0] !== 4'b0101) begin errors++; $display("FAIL ovf_add_flags got=%b want=0101", r[3:0]); end
        drive_one8(8'd128, 8'd1, 1'b1, 1'b0, lat, r);
        checks++; if (r[11:4] !== 8'd127) begin errors++; $display("FAIL ovf_sub_y got=%0d want=127", r[11:4]); end
        checks++; if (r[3:0] !== 4'b1100) begin errors++; $display("FAIL ovf_sub_flags got=%b want=1100", r[3:0]); end
`ifdef ADDSUB_SAT_EN
        drive_one8(8'd127, 8'd1, 1'b0, 1'b1, lat, r);
        checks++; if (r[11:4] !== 8'd127) begin errors++; $display("FAIL sat_add_y got=%0d want=127", r[11:4]); end
        checks++; if (r[3:0] !== 4'b0100) begin errors++; $display("FAIL sat_add_flags got=%b want=0100", r[3:0]); end
        drive_one8(8'd128, 8'd1, 1'b1, 1'b1, lat, r);
        checks++; if (r[11:4] !== 8'd128) begin errors++; $display("FAIL sat_sub_y got=%0d want=128", r[11:4]); end
        checks++; if (r[3:0] !== 4'b1101) begin errors++; $display("FAIL sat_sub_flags got=%b want=1101", r[3:0]); end
        sat8 = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        int waited;
        @(posedge clk); #1;
        clear_sb();
        out_ready8 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0; sat8 = 1'b0;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
                sat8 = SAT_BUILD & 1'($urandom);
            end
            in_valid8 = 1'b1;
            checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready beat=%0d got=%b want=1", i, in_ready8); end
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0; sat8 = 1'b0;
        waited = 0;
        while (obs_q.size() < 17 && waited < 10) begin @(posedge clk); #1; waited++; end
        checks++; if (obs_q.size() != 17 || exp_q.size() != 17) begin errors++; $display("FAIL b2b_count got=%0d/%0d want=17", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < 17 && i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_result beat=%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_t.size() == 17) begin
            checks++; if (obs_t[16] - obs_t[0] != 16) begin errors++; $display("FAIL b2b_throughput span got=%0d want=16", obs_t[16] - obs_t[0]); end
            checks++; if (obs_q[16][11:4] !== 8'h10) begin errors++; $display("FAIL b2b_cross_chunk got=%h want=10", obs_q[16][11:4]); end
        end
    endtask

    task automatic test_stall();
        logic acc; logic [11:0] hold; int tries, waited;
        @(posedge clk); #1;
        clear_sb();
        out_ready8 = 1'b0;
        tries = 0;
        while (tries < 10) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); in_valid8 = 1'b1;
            @(negedge clk);
            acc = in_ready8;
            if (!acc) break;
            @(posedge clk); #1;
            tries++;
        end
        checks++; if (exp_q.size() != 2) begin errors++; $display("FAIL stall_fill accepted=%0d want=2", exp_q.size()); end
        @(posedge clk); #1;
        hold = {y8, carry8, ovf8, zero8, neg8};
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready8 !== 1'b0 || out_valid8 !== 1'b1) begin errors++; $display("FAIL stall_handshake cyc=%0d in_ready=%b out_valid=%b want=0/1", i, in_ready8, out_valid8); end
            checks++; if ({y8, carry8, ovf8, zero8, neg8} !== hold) begin errors++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, {y8, carry8, ovf8, zero8, neg8}, hold); end
            @(posedge clk); #1;
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        waited = 0;
        while (obs_q.size() < 3 && waited < 10) begin @(posedge clk); #1; waited++; end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (obs_q.size() != 3 || exp_q.size() != 3) begin errors++; $display("FAIL stall_count got=%0d/%0d want=3", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_result beat=%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        clear_sb();
        out_ready8 = 1'b1;
        a8 = 8'd3; b8 = 8'd4; sub8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'd50; b8 = 8'd7; sub8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", out_valid8); end
        checks++; if ({y8, carry8, ovf8, zero8, neg8} !== 12'h000) begin errors++; $display("FAIL midrst_outputs got=%h want=000", {y8, carry8, ovf8, zero8, neg8}); end
        @(posedge clk); #1;
        clear_sb();
        rst = 1'b0;
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b want=1", in_ready8); end
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (obs_q.size() != 0 || out_valid8 !== 1'b0) begin errors++; $display("FAIL midrst_ghost results=%0d out_valid=%b want=0/0", obs_q.size(), out_valid8); end
    endtask

    task automatic test_wide32();
        int lat; logic [35:0] r, e; logic [31:0] ra, rb; logic rs;
        drive_one32(32'd10, 32'd20, 1'b0, lat, r);
        checks++; if (lat !== 4) begin errors++; $display("FAIL w32_latency got=%0d want=4", lat); end
        checks++; if (r !== {32'd30, 4'b0000}) begin errors++; $display("FAIL w32_add got=%h want=%h", r, {32'd30, 4'b0000}); end
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            if (i == 0) begin ra = 32'h7FFF_FFFF; rb = 32'h1; rs = 1'b0; end
            if (i == 1) begin ra = 32'h0000_00FF; rb = 32'h1; rs = 1'b0; end
            e = model32(ra, rb, rs);
            drive_one32(ra, rb, rs, lat, r);
            checks++; if (r !== e || lat !== 4) begin errors++; $display("FAIL w32_random i=%0d got=%h lat=%0d want=%h lat=4", i, r, lat, e); end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; sat8 = 1'b0;
        in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0; sat32 = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_wide32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
